// File: rtl/mac_pipe.sv
// Two-stage multi-lane signed multiply-accumulate with framed sums, beat count and sticky overflow.
// Optional saturation of the accumulator on overflow: define MAC_PIPE_SAT_EN.
module mac_pipe #(
  parameter int DATA_W = 8,
  parameter int LANES  = 4,
  parameter int ACC_W  = 26,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr_n,
  input  logic                     in_vld,
  input  logic                     in_last,
  input  logic [LANES*DATA_W-1:0]  in1,
  input  logic [LANES*DATA_W-1:0]  in2,
  output logic signed [ACC_W-1:0]  acc,
  output logic                     acc_vld,
  output logic [CNT_W-1:0]         cnt,
  output logic                     ovf
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int PSUM_W = 2 * DATA_W + $clog2(LANES) + 1;
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic {ST_CLOSED = 1'b0, ST_OPEN = 1'b1} sum_state_e;

  sum_state_e                r_state, w_state_nxt;
  logic                      w_first;

  logic signed [PROD_W-1:0]  w_prod [LANES];
  logic signed [PSUM_W-1:0]  w_psum;
  logic signed [PSUM_W-1:0]  r_psum;
  logic                      r_p_vld;
  logic                      r_p_last;

  logic signed [ACC_W-1:0]   w_ext;
  logic signed [ACC_W-1:0]   w_sum;
  logic signed [ACC_W-1:0]   w_acc_nxt;
  logic                      w_add_ovf;
  logic [CNT_W-1:0]          w_cnt_inc;

  logic signed [ACC_W-1:0]   r_acc;
  logic                      r_acc_vld;
  logic [CNT_W-1:0]          r_cnt;
  logic                      r_ovf;

  // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    w_psum = '0;
    for (int i = 0; i < LANES; i++) begin
      w_prod[i] = $signed(in1[i*DATA_W +: DATA_W]) * $signed(in2[i*DATA_W +: DATA_W]);
      w_psum    = w_psum + PSUM_W'(w_prod[i]);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; reset is asynchronous, clear synchronous.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p_vld  <= 1'b0;
      r_p_last <= 1'b0;
      r_psum   <= '0;
    end else if (!clr_n) begin
      r_p_vld  <= 1'b0;
      r_p_last <= 1'b0;
      r_psum   <= '0;
    end else begin
      r_p_vld  <= in_vld;
      r_p_last <= in_vld & in_last;
      if (in_vld) r_psum <= w_psum;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_state <= ST_CLOSED;
    else if (!clr_n)  r_state <= ST_CLOSED;
    else              r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_p_vld) w_state_nxt = r_p_last ? ST_CLOSED : ST_OPEN;
  end

  always_comb begin
    w_first = (r_state == ST_CLOSED);
  end

  // Overflow: equal operand signs with a result sign that differs from them.
  always_comb begin
    w_ext     = ACC_W'(r_psum);
    w_sum     = r_acc + w_ext;
    w_add_ovf = (r_acc[ACC_W-1] == w_ext[ACC_W-1]) && (w_sum[ACC_W-1] != r_acc[ACC_W-1]);
    w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + 1'b1;
`ifdef MAC_PIPE_SAT_EN
    w_acc_nxt = w_add_ovf ? (w_ext[ACC_W-1] ? ACC_MIN : ACC_MAX) : w_sum;
`else
    w_acc_nxt = w_sum;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc     <= '0;
      r_acc_vld <= 1'b0;
      r_cnt     <= '0;
      r_ovf     <= 1'b0;
    end else if (!clr_n) begin
      r_acc     <= '0;
      r_acc_vld <= 1'b0;
      r_cnt     <= '0;
      r_ovf     <= 1'b0;
    end else begin
      r_acc_vld <= r_p_vld & r_p_last;
      if (r_p_vld) begin
        if (w_first) begin
          r_acc <= w_ext;
          r_cnt <= CNT_W'(1);
          r_ovf <= 1'b0;
        end else begin
          r_acc <= w_acc_nxt;
          r_cnt <= w_cnt_inc;
          r_ovf <= r_ovf | w_add_ovf;
        end
      end
    end
  end

  assign acc     = r_acc;
  assign acc_vld = r_acc_vld;
  assign cnt     = r_cnt;
  assign ovf     = r_ovf;

endmodule

// File: tb/tb_mac_pipe.sv
// Self-checking bench for mac_pipe: directed cases plus random beats against a sum-level reference model.
// Expected overflow behaviour follows MAC_PIPE_SAT_EN the same way the design does.
module tb_mac_pipe;

  localparam int DATA_W = 8;
  localparam int LANES  = 4;
  localparam int ACC_W  = 26;
  localparam int CNT_W  = 16;
  localparam int VW     = LANES * DATA_W;

  localparam longint ACC_MAX = (longint'(1) <<< (ACC_W - 1)) - 1;
  localparam longint ACC_MIN = -(longint'(1) <<< (ACC_W - 1));
  localparam longint ACC_MOD = longint'(1) <<< ACC_W;
  localparam longint CNT_MAX = (longint'(1) <<< CNT_W) - 1;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    clr_n = 1'b1;
  logic                    in_vld = 1'b0;
  logic                    in_last = 1'b0;
  logic [VW-1:0]           in1 = '0;
  logic [VW-1:0]           in2 = '0;
  logic signed [ACC_W-1:0] acc;
  logic                    acc_vld;
  logic [CNT_W-1:0]        cnt;
  logic                    ovf;

  mac_pipe #(.DATA_W(DATA_W), .LANES(LANES), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .clr_n(clr_n), .in_vld(in_vld), .in_last(in_last),
    .in1(in1), .in2(in2), .acc(acc), .acc_vld(acc_vld), .cnt(cnt), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: one completed sum per entry, tagged with the cycle its pulse is due.
  typedef struct {
    int     cyc;
    longint acc;
    longint cnt;
    bit     ovf;
  } exp_t;

  exp_t   q[$];
  longint m_acc;
  longint m_cnt;
  bit     m_ovf;
  bit     m_open;

  function automatic longint dot(input logic [VW-1:0] x, input logic [VW-1:0] y);
    longint s = 0;
    for (int i = 0; i < LANES; i++)
      s += longint'($signed(x[i*DATA_W +: DATA_W])) * longint'($signed(y[i*DATA_W +: DATA_W]));
    return s;
  endfunction

  function automatic logic [VW-1:0] pk(input int l0, input int l1, input int l2, input int l3);
    logic [VW-1:0] v;
    v[7:0]   = 8'(l0);
    v[15:8]  = 8'(l1);
    v[23:16] = 8'(l2);
    v[31:24] = 8'(l3);
    return v;
  endfunction

  task automatic model_reset();
    m_acc  = 0;
    m_cnt  = 0;
    m_ovf  = 0;
    m_open = 0;
    q.delete();
  endtask

  task automatic model_step(input longint p, input bit l);
    longint s;
    if (!m_open) begin
      m_acc = p;
      m_cnt = 1;
      m_ovf = 0;
    end else begin
      s = m_acc + p;
      if (s > ACC_MAX || s < ACC_MIN) begin
        m_ovf = 1;
`ifdef MAC_PIPE_SAT_EN
        s = (s > ACC_MAX) ? ACC_MAX : ACC_MIN;
`else
        s = (s > ACC_MAX) ? s - ACC_MOD : s + ACC_MOD;
`endif
      end
      m_acc = s;
      m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
    end
    m_open = !l;
    if (l) q.push_back('{cyc + 1, m_acc, m_cnt, m_ovf});
  endtask

  // Present one cycle of input; called at posedge+1, returns at the next posedge+1.
  task automatic beat(input logic [VW-1:0] x, input logic [VW-1:0] y, input bit v, input bit l);
    in1 = x; in2 = y; in_vld = v; in_last = l;
    @(posedge clk); #1;
    if (v) model_step(dot(x, y), l);
    in_vld = 0; in_last = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) beat(pk(0, 0, 0, 0), pk(0, 0, 0, 0), 1'b0, 1'b0);
  endtask

  task automatic check_outputs(input string tag, input longint e_acc, input longint e_cnt, input bit e_ovf);
    check({tag, "_acc"}, acc, e_acc);
    check({tag, "_cnt"}, cnt, e_cnt);
    check({tag, "_ovf"}, ovf, e_ovf);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (q.size() > 0 && q[0].cyc == cyc) begin
        check("pulse_vld", acc_vld, 1);
        check("pulse_acc", acc, q[0].acc);
        check("pulse_cnt", cnt, q[0].cnt);
        check("pulse_ovf", ovf, q[0].ovf);
        void'(q.pop_front());
      end else if (acc_vld) begin
        check("acc_vld_spurious", acc_vld, 0);
      end
    end
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset", 0, 0, 0);
    check("reset_vld", acc_vld, 0);
    #2 rst_n = 1;
    @(posedge clk); #1;

    // Single active lane
    beat(pk(3, 0, 0, 0), pk(4, 0, 0, 0), 1, 0);
    beat(pk(-5, 0, 0, 0), pk(6, 0, 0, 0), 1, 0);
    beat(pk(7, 0, 0, 0), pk(-8, 0, 0, 0), 1, 1);
    idle(3);
    check_outputs("single", -74, 3, 0);

    // Four lanes, back-to-back single-beat sums
    beat(pk(-128, -128, -128, -128), pk(-128, -128, -128, -128), 1, 1);
    beat(pk(1, 1, 1, 1), pk(1, 1, 1, 1), 1, 1);
    idle(3);
    check_outputs("four_lane", 4, 1, 0);

    // Overflow on the final beat of 2048
    repeat (2047) beat(pk(-128, 0, 0, 0), pk(-128, 0, 0, 0), 1, 0);
    beat(pk(-128, 0, 0, 0), pk(-128, 0, 0, 0), 1, 1);
    idle(3);
`ifdef MAC_PIPE_SAT_EN
    check_outputs("ovf", 33554431, 2048, 1);
`else
    check_outputs("ovf", -33554432, 2048, 1);
`endif
    beat(pk(2, 0, 0, 0), pk(3, 0, 0, 0), 1, 1);
    idle(3);
    check_outputs("after_ovf", 6, 1, 0);

    // Synchronous clear while a third beat is valid
    beat(pk(10, 0, 0, 0), pk(10, 0, 0, 0), 1, 0);
    beat(pk(10, 0, 0, 0), pk(10, 0, 0, 0), 1, 0);
    in1 = pk(10, 0, 0, 0); in2 = pk(10, 0, 0, 0); in_vld = 1; in_last = 1; clr_n = 0;
    @(posedge clk); #1;
    clr_n = 1; in_vld = 0; in_last = 0;
    model_reset();
    idle(3);
    check_outputs("clear", 0, 0, 0);
    beat(pk(1, 0, 0, 0), pk(1, 0, 0, 0), 1, 1);
    idle(3);
    check_outputs("after_clear", 1, 1, 0);

    // Asynchronous reset between edges, mid-sum
    beat(pk(5, 0, 0, 0), pk(5, 0, 0, 0), 1, 0);
    beat(pk(5, 0, 0, 0), pk(5, 0, 0, 0), 1, 0);
    #3 rst_n = 0;
    model_reset();
    #1;
    check_outputs("async_rst", 0, 0, 0);
    check("async_rst_vld", acc_vld, 0);
    #2 rst_n = 1;
    @(posedge clk); #1;
    beat(pk(2, 0, 0, 0), pk(2, 0, 0, 0), 1, 1);
    idle(3);
    check_outputs("after_rst", 4, 1, 0);

    // Idle cycles carrying in_last must be ignored
    beat(pk(3, 0, 0, 0), pk(3, 0, 0, 0), 1, 0);
    beat(pk(7, 7, 7, 7), pk(7, 7, 7, 7), 0, 1);
    beat(pk(4, 0, 0, 0), pk(4, 0, 0, 0), 1, 0);
    beat(pk(7, 7, 7, 7), pk(7, 7, 7, 7), 0, 1);
    beat(pk(5, 0, 0, 0), pk(5, 0, 0, 0), 1, 1);
    idle(3);
    check_outputs("gaps", 50, 3, 0);

    // Random beats, gaps and sum lengths
    for (int i = 0; i < 400; i++) begin
      beat($urandom, $urandom, $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0);
    end
    beat($urandom, $urandom, 1, 1);
    idle(4);
    check("pending_results", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mac_pipe.md
# mac_pipe

Pipelined, multi-lane signed multiply-accumulate for the SNN datapath: successor to the single-lane MAC, used by the neuron layer to form dot products of 8-bit inputs and weights. Each accepted beat multiplies LANES operand pairs, reduces them through an adder tree, and accumulates into a wide signed sum. The block frames sums with a `last` marker, pulses a result-valid, tracks the beat count, and flags overflow.

## Interface
- DATA_W, 8, signed operand width per lane
- LANES, 4, operand pairs per beat (≥1)
- ACC_W, 26, accumulator width; must be ≥ 2*DATA_W + $clog2(LANES) + 1
- CNT_W, 16, beat-counter width
- clk  input  1  system clock, 50 MHz
- rst_n  input  1  reset, asynchronous, active-low
- clr_n  input  1  synchronous clear, active-low; flushes the pipeline and the accumulator
- in_vld  input  1  beat valid; always accepted, no backpressure
- in_last  input  1  final beat of the current sum; qualified by in_vld
- in1  input  LANES*DATA_W  packed signed operands; lane i is [i*DATA_W +: DATA_W]
- in2  input  LANES*DATA_W  packed signed operands, same packing
- acc  output  ACC_W  signed running or final sum
- acc_vld  output  1  one-cycle pulse: acc holds a completed sum
- cnt  output  CNT_W  beats accumulated into the current or last sum; saturates at all-ones
- ovf  output  1  sticky signed overflow for the current or last sum

## Operation
- Stage 1, registered on an accepted beat:
  - Each lane forms a signed product of 2*DATA_W bits.
  - Lane products are sign-extended and summed to `psum`.
  - `p_vld` and `p_last` register in_vld and in_last.
- Stage 2 runs when `p_vld` is set:
  - `psum` is sign-extended to ACC_W.
  - If the sum is closed (after reset, after clr_n, or after a completed `last`): acc = psum, cnt = 1, ovf = 0.
  - Otherwise: acc = acc + psum, cnt = cnt + 1 (saturating at all-ones), and ovf |= signed overflow of the add.
- The sum closes when the beat carrying `p_last` is accumulated. acc_vld pulses on that update.
- While the sum is closed, acc, cnt and ovf hold until the next beat's stage-2 update.
- Sum state is one flag, `open`:
  - CLOSED→OPEN on a stage-2 beat with !p_last.
  - OPEN→CLOSED on a stage-2 beat with p_last.
  - A CLOSED beat with p_last is a single-beat sum; the state stays CLOSED and acc_vld pulses.
- Overflow: the add overflows when both operands have equal sign and the result sign differs. Without saturation, the result wraps modulo 2^ACC_W.
- In-flight beats are never dropped except by clr_n or rst_n.

## Timing
- Reset (rst_n low): acc = 0, acc_vld = 0, cnt = 0, ovf = 0, stage-1 registers cleared, state CLOSED. Reset takes effect immediately at any point mid-sum.
- Latency:
  - Beat sampled at edge k → psum at edge k → acc updated at edge k+1.
  - acc_vld is high from edge k+1 to edge k+2 for a `last` beat.
- Throughput: one beat per cycle, back-to-back sums with no bubble. The first beat of sum N+1 may be accepted while the result of sum N is in the pipe.
- clr_n low at edge k: all registers take their reset values at edge k.
  - Any beat presented or in flight is discarded.
  - clr_n wins over a simultaneous in_vld.
- in_last with in_vld = 0 is ignored.

## Configuration
- MAC_PIPE_SAT_EN defined: on overflow, acc clamps to +(2^(ACC_W-1))-1 or -2^(ACC_W-1) according to the sign of psum. ovf still sets. Later beats add from the clamped value.
- MAC_PIPE_SAT_EN undefined: acc wraps (two's complement); ovf still sets.

## Test plan
- Single lane:
  - LANES = 1, beats (3,4), (-5,6), (7,-8, last) → acc = -74, acc_vld pulses exactly 1 cycle, 2 cycles after the last beat; cnt = 3; ovf = 0.
- Four lanes:
  - LANES = 4, one beat with all lanes (-128,-128), last → acc = 65536, cnt = 1.
  - Next beat all lanes (1,1), last, back-to-back → acc = 4, second acc_vld pulse on the following cycle.
- Overflow:
  - LANES = 1, 2048 beats of (-128,-128), last on the final beat.
  - Without the macro → acc = -33554432, ovf = 1.
  - With MAC_PIPE_SAT_EN → acc = 33554431, ovf = 1.
  - Either way, a following single beat (2,3, last) → acc = 6, ovf = 0.
- Clear mid-sum:
  - Two beats of (10,10), then clr_n low for 1 cycle while a third beat is valid.
  - Required: acc = 0, cnt = 0, no acc_vld.
  - Next beat (1,1, last) → acc = 1.
- Reset mid-sum:
  - rst_n low asynchronously between edges → all outputs 0 immediately.
  - After release, beat (2,2, last) → acc = 4, cnt = 1.
- Gaps and qualification:
  - in_vld toggling 1,0,1,0 with in_last held high on the idle cycles → idle cycles ignored; only valid beats counted.
